// File: rtl/tsu_pkg.sv
// Shared types for the tsu info stream: the info beat, receiver lock states and the marker timestamp entry.
// No logic here beyond a saturating counter helper.
// Used by both ends of the stream; the receiver imports it whole.
package tsu_pkg;

    localparam int PHASE_B_WIDTH   = 32;
    localparam int FCLK_DIV_BITS   = 3;
    localparam int TSU_EPOCH_WIDTH = 16;

    localparam int                       TSU_LOCK_CNT_DEF   = 3;
    localparam logic [PHASE_B_WIDTH-1:0] TSU_PHASE_STEP_DEF = 32'h0000_0100;

    typedef struct packed {
        logic                     marker_v;
        logic [PHASE_B_WIDTH-1:0] phase_b;
    } info;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [TSU_EPOCH_WIDTH-1:0] epoch;
        logic [PHASE_B_WIDTH-1:0]   phase;
    } ts_entry;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tsu_ts_fifo.sv
// Synchronous FIFO of marker timestamp entries; DEPTH must be a power of two.
// Latency: a push into an empty FIFO is visible at the head one clock later.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module tsu_ts_fifo
    import tsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  ts_entry push_dat,
    input  logic    pop,
    output ts_entry head_dat,
    output logic    empty,
    output logic    full
);

    localparam int AW = $clog2(DEPTH);

    ts_entry         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tsu_info_rx.sv
// Info stream receiver: cadence lock, epoch extension of phase_b, marker timestamps queued for PTP logic.
// Latency: a marker on beat cycle N shows at the ts port on N+1 when the queue is empty.
// Backpressure: ts port is valid/ready; markers arriving with the queue full are dropped and counted. Optional step check: TSU_INFO_RX_STEP_CHK_EN.
module tsu_info_rx
    import tsu_pkg::*;
#(
    parameter int EPOCH_WIDTH = TSU_EPOCH_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int LOCK_CNT    = TSU_LOCK_CNT_DEF
`ifdef TSU_INFO_RX_STEP_CHK_EN
    ,
    parameter logic [PHASE_B_WIDTH-1:0] PHASE_STEP = TSU_PHASE_STEP_DEF
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_v,
    input  info                      in_info,
    output logic                     ts_v,
    input  logic                     ts_rdy,
    output logic [EPOCH_WIDTH-1:0]   ts_epoch,
    output logic [PHASE_B_WIDTH-1:0] ts_phase,
    output logic                     lock,
    output logic [7:0]               drop_cnt,
    output logic [7:0]               step_err_cnt
);

    localparam logic [FCLK_DIV_BITS-1:0] DIV_MAX = '1;

    rx_state_e                state_q, state_d;
    logic [FCLK_DIV_BITS-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]               good_cnt_q, good_cnt_d;
    logic [EPOCH_WIDTH-1:0]   epoch_q, epoch_d;
    logic [PHASE_B_WIDTH-1:0] last_phase_q, last_phase_d;
    logic [7:0]               drop_cnt_q;

    logic    spacing_ok;
    logic    spacing_fault;
    logic    step_err_evt;
    logic    push;
    logic    pop;
    logic    fifo_full;
    logic    fifo_empty;
    ts_entry push_dat;
    ts_entry head_dat;

    // div_cnt saturates so a missed beat stays visible as a fault until the next in_v.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (in_v)                     div_cnt_d = '0;
        else if (div_cnt_q != DIV_MAX) div_cnt_d = div_cnt_q + FCLK_DIV_BITS'(1);
    end

    assign spacing_ok    = in_v && (div_cnt_q == DIV_MAX);
    assign spacing_fault = (in_v && (div_cnt_q != DIV_MAX)) || (!in_v && (div_cnt_q == DIV_MAX));

`ifdef TSU_INFO_RX_STEP_CHK_EN
    logic [7:0] step_err_q;

    assign step_err_evt = spacing_ok && (state_q != UNLOCKED) &&
                          (in_info.phase_b != last_phase_q + PHASE_STEP);
    assign step_err_cnt = step_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            step_err_q <= '0;
        else if (step_err_evt) step_err_q <= sat_inc8(step_err_q);
    end
`else
    assign step_err_evt = 1'b0;
    assign step_err_cnt = '0;
`endif

    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        epoch_d      = epoch_q;
        last_phase_d = last_phase_q;
        push         = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (in_v) begin
                    state_d      = LOCKING;
                    good_cnt_d   = '0;
                    epoch_d      = '0;
                    last_phase_d = in_info.phase_b;
                end
            end
            LOCKING: begin
                if (spacing_fault || step_err_evt) begin
                    state_d = UNLOCKED;
                end else if (spacing_ok) begin
                    good_cnt_d   = good_cnt_q + 4'd1;
                    last_phase_d = in_info.phase_b;
                    if (good_cnt_d == 4'(LOCK_CNT)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (spacing_fault || step_err_evt) begin
                    state_d = UNLOCKED;
                end else if (spacing_ok) begin
                    if (in_info.phase_b < last_phase_q) epoch_d = epoch_q + EPOCH_WIDTH'(1);
                    last_phase_d = in_info.phase_b;
                    push         = in_info.marker_v;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // The pushed epoch already includes a wrap detected on this very beat.
    assign push_dat = '{epoch: TSU_EPOCH_WIDTH'(epoch_d), phase: in_info.phase_b};
    assign pop      = ts_v && ts_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= UNLOCKED;
            div_cnt_q    <= '0;
            good_cnt_q   <= '0;
            epoch_q      <= '0;
            last_phase_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            good_cnt_q   <= good_cnt_d;
            epoch_q      <= epoch_d;
            last_phase_q <= last_phase_d;
            if (push && fifo_full && !pop) drop_cnt_q <= sat_inc8(drop_cnt_q);
        end
    end

    tsu_ts_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign ts_v     = !fifo_empty;
    assign ts_epoch = EPOCH_WIDTH'(head_dat.epoch);
    assign ts_phase = head_dat.phase;
    assign lock     = (state_q == LOCKED);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_tsu_info_rx.sv
// Bench for tsu_info_rx: hand vectors for lock, capture, wrap, spacing, overflow and step cases,
// then random beats against a queue-based reference model.
module tb_tsu_info_rx;
    import tsu_pkg::*;

    localparam logic [31:0] STEP  = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam int          LCNT  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_v = 1'b0;
    info         in_info = '0;
    logic        ts_v;
    logic        ts_rdy = 1'b0;
    logic [15:0] ts_epoch;
    logic [31:0] ts_phase;
    logic        lock;
    logic [7:0]  drop_cnt;
    logic [7:0]  step_err_cnt;

    int checks = 0;
    int errors = 0;
    bit rdy_g  = 1'b0;

    always #5 clk = ~clk;

    tsu_info_rx #(
        .EPOCH_WIDTH (16),
        .FIFO_DEPTH  (DEPTH),
        .LOCK_CNT    (LCNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_v         (in_v),
        .in_info      (in_info),
        .ts_v         (ts_v),
        .ts_rdy       (ts_rdy),
        .ts_epoch     (ts_epoch),
        .ts_phase     (ts_phase),
        .lock         (lock),
        .drop_cnt     (drop_cnt),
        .step_err_cnt (step_err_cnt)
    );

    // Reference model: clocks since last beat, lock flags, and a queue for the timestamp FIFO.
    typedef struct { logic [15:0] ep; logic [31:0] ph; } ent_t;
    ent_t        mq[$];
    int          m_since;
    bit          m_locking, m_locked;
    int          m_good;
    logic [15:0] m_ep;
    logic [31:0] m_last;
    int          m_drop, m_serr;

    function automatic void model_reset();
        mq.delete();
        m_since = 0; m_locking = 0; m_locked = 0; m_good = 0;
        m_ep = '0; m_last = '0; m_drop = 0; m_serr = 0;
    endfunction

    function automatic void model_step(input bit v, input bit mk, input logic [31:0] ph, input bit rdy);
        bit   pop, push, good, fault, step_bad;
        ent_t e;
        pop  = (mq.size() != 0) && rdy;
        push = 0;
        e    = '{ep: '0, ph: '0};
        m_since++;
        good     = v && (m_since == 8);
        fault    = (v && m_since != 8) || (!v && m_since == 8);
        step_bad = 0;
`ifdef TSU_INFO_RX_STEP_CHK_EN
        step_bad = (ph != m_last + STEP);
`endif
        if (!m_locking && !m_locked) begin
            if (v) begin
                m_locking = 1; m_good = 0; m_ep = '0; m_last = ph;
            end
        end else if (fault) begin
            m_locking = 0; m_locked = 0;
        end else if (good) begin
            if (step_bad) begin
                m_locking = 0; m_locked = 0;
                if (m_serr < 255) m_serr++;
            end else if (m_locking) begin
                m_good++;
                m_last = ph;
                if (m_good == LCNT) begin m_locking = 0; m_locked = 1; end
            end else begin
                if (ph < m_last) m_ep = m_ep + 16'd1;
                m_last = ph;
                if (mk) begin push = 1; e = '{ep: m_ep, ph: ph}; end
            end
        end
        if (v) m_since = 0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else if (m_drop < 255) m_drop++;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("m_lock", 64'(lock), 64'(m_locked));
        chk("m_ts_v", 64'(ts_v), 64'(mq.size() != 0));
        chk("m_drop", 64'(drop_cnt), 64'(m_drop));
        chk("m_serr", 64'(step_err_cnt), 64'(m_serr));
        if (mq.size() != 0) begin
            chk("m_epoch", 64'(ts_epoch), 64'(mq[0].ep));
            chk("m_phase", 64'(ts_phase), 64'(mq[0].ph));
        end
    endtask

    // One clock: inputs are applied at posedge+1 and outputs sampled at the next posedge+1.
    task automatic cyc(input bit v, input bit mk, input logic [31:0] ph, input bit rdy);
        in_v             = v;
        in_info.marker_v = mk;
        in_info.phase_b  = ph;
        ts_rdy           = rdy;
        model_step(v, mk, ph, rdy);
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic beat(input bit mk, input logic [31:0] ph);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 32'h0, rdy_g);
        cyc(1'b1, mk, ph, rdy_g);
    endtask

    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        in_v   = 1'b0;
        ts_rdy = 1'b0;
        #1;
        chk("rst_lock", 64'(lock), 64'd0);
        chk("rst_ts_v", 64'(ts_v), 64'd0);
        chk("rst_epoch", 64'(ts_epoch), 64'd0);
        chk("rst_phase", 64'(ts_phase), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_serr", 64'(step_err_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic lock_at(input logic [31:0] p0);
        for (int i = 0; i < 4; i++) beat(1'b0, p0 + STEP * i);
        chk("lock_up", 64'(lock), 64'd1);
    endtask

    typedef struct {
        bit          mk;
        logic [31:0] ph;
        bit          e_lock;
        bit          e_tsv;
        logic [15:0] e_ep;
        logic [31:0] e_ph;
    } vec_t;

    vec_t vt[5];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{mk: 1, ph: 32'h1234_5200, e_lock: 0, e_tsv: 0, e_ep: 16'h0, e_ph: 32'h0};
        vt[1] = '{mk: 1, ph: 32'h1234_5300, e_lock: 0, e_tsv: 0, e_ep: 16'h0, e_ph: 32'h0};
        vt[2] = '{mk: 1, ph: 32'h1234_5400, e_lock: 0, e_tsv: 0, e_ep: 16'h0, e_ph: 32'h0};
        vt[3] = '{mk: 1, ph: 32'h1234_5500, e_lock: 1, e_tsv: 0, e_ep: 16'h0, e_ph: 32'h0};
        vt[4] = '{mk: 1, ph: 32'h1234_5600, e_lock: 1, e_tsv: 1, e_ep: 16'h0, e_ph: 32'h1234_5600};

        @(posedge clk);
        #1;
        do_reset();

        // Lock acquisition and first capture
        rdy_g = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(vt[i].mk, vt[i].ph);
            chk("tbl_lock", 64'(lock), 64'(vt[i].e_lock));
            chk("tbl_ts_v", 64'(ts_v), 64'(vt[i].e_tsv));
            if (vt[i].e_tsv) begin
                chk("tbl_epoch", 64'(ts_epoch), 64'(vt[i].e_ep));
                chk("tbl_phase", 64'(ts_phase), 64'(vt[i].e_ph));
            end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            chk("hold_ts_v", 64'(ts_v), 64'd1);
            chk("hold_phase", 64'(ts_phase), 64'h1234_5600);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("pop_ts_v", 64'(ts_v), 64'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h1234_5700, 1'b1);
        chk("still_lock", 64'(lock), 64'd1);

        // Phase wrap bumps the epoch on the wrapping beat itself
        do_reset();
        lock_at(32'hFFFF_FB00);
        beat(1'b0, 32'hFFFF_FF00);
        beat(1'b1, 32'h0000_0000);
        chk("wrap_ts_v", 64'(ts_v), 64'd1);
        chk("wrap_epoch", 64'(ts_epoch), 64'd1);
        chk("wrap_phase", 64'(ts_phase), 64'd0);

        // Early beat, then a missed beat; queued entry survives both
        do_reset();
        lock_at(32'h100);
        beat(1'b1, 32'h500);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h600, 1'b0);
        chk("early_lock", 64'(lock), 64'd0);
        chk("early_ts_v", 64'(ts_v), 64'd1);
        lock_at(32'h700);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_miss_lock", 64'(lock), 64'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk("miss_lock", 64'(lock), 64'd0);
        chk("miss_phase", 64'(ts_phase), 64'h500);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        chk("miss_drain", 64'(ts_v), 64'd0);

        // Overflow, then a full push with a same-cycle pop
        do_reset();
        rdy_g = 1'b0;
        lock_at(32'h100);
        for (int i = 0; i < 6; i++) beat(1'b1, 32'h500 + STEP * i);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        chk("ovf_head", 64'(ts_phase), 64'h500);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'hB00, 1'b1);
        chk("pp_drop", 64'(drop_cnt), 64'd2);
        chk("pp_head", 64'(ts_phase), 64'h600);
        chk("pp_ts_v", 64'(ts_v), 64'd1);

        // Step jump of 2*STEP
        do_reset();
        lock_at(32'h100);
        beat(1'b0, 32'h600);
`ifdef TSU_INFO_RX_STEP_CHK_EN
        chk("step_lock", 64'(lock), 64'd0);
        chk("step_cnt", 64'(step_err_cnt), 64'd1);
`else
        chk("step_lock", 64'(lock), 64'd1);
        chk("step_cnt", 64'(step_err_cnt), 64'd0);
`endif

        // Random beats against the model
        do_reset();
        begin
            logic [31:0] ph;
            int          gap, r, r2;
            ph = $urandom;
            for (int b = 0; b < 400; b++) begin
                r  = $urandom_range(0, 19);
                gap = (r == 0) ? $urandom_range(1, 7) : (r == 1) ? $urandom_range(9, 12) : 8;
                r2 = $urandom_range(0, 15);
                if (r2 == 0)      ph = $urandom;
                else if (r2 == 1) ph = 32'hFFFF_FD00;
                else              ph = ph + STEP;
                for (int i = 0; i < gap - 1; i++)
                    cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
                cyc(1'b1, 1'($urandom_range(0, 1)), ph, ($urandom_range(0, 3) == 0));
            end
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tsu_info_rx.md
Name: tsu_info_rx

Overview:
- Receive end of the tsu_pkg::info stream. The transmitter emits one info beat every 2^FCLK_DIV_BITS clocks: phase_b plus a marker_v flag.
- Checks beat cadence and maintains lock.
- Extends phase_b with an epoch counter across phase wrap.
- Timestamps every marker into a small FIFO drained through a valid/ready port by the PTP event logic.

Parameters:
- EPOCH_WIDTH, 16: width of the wrap-extension counter prepended to phase_b.
- FIFO_DEPTH, 4: marker timestamp FIFO entries; power of two, at least 2.
- LOCK_CNT, 3: consecutive correctly spaced beats needed in LOCKING before entering LOCKED; range 1..15.
- PHASE_STEP, 32'h0000_0100: expected phase_b increment per beat, modulo 2^PHASE_B_WIDTH. Used only with the optional feature.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- in_v, in, 1: info beat valid.
- in_info, in, tsu_pkg::info (1+PHASE_B_WIDTH bits): beat payload.
- ts_v, out, 1: timestamp valid (FIFO head).
- ts_rdy, in, 1: consumer ready.
- ts_epoch, out, EPOCH_WIDTH: head epoch.
- ts_phase, out, PHASE_B_WIDTH: head phase_b.
- lock, out, 1: state==LOCKED.
- drop_cnt, out, 8: saturating count of markers dropped because the FIFO was full.
- step_err_cnt, out, 8: saturating count of phase step errors (optional feature).

Behaviour:
- Reset values: all outputs 0. State UNLOCKED, div_cnt 0, epoch 0, last_phase 0, FIFO empty.
- div_cnt (FCLK_DIV_BITS bits) counts clocks since the last in_v:
  - Cleared to 0 on each in_v.
  - Otherwise increments, saturating at all-ones.
- A beat is good iff in_v is high and div_cnt == 2^FCLK_DIV_BITS-1, i.e. exactly 2^FCLK_DIV_BITS clocks since the previous beat.
- Spacing fault:
  - in_v with div_cnt != all-ones, or
  - div_cnt already at all-ones with no in_v (a missed beat).
- FSM:
  - UNLOCKED: any in_v -> LOCKING. good_cnt=0, epoch=0, last_phase=in_info.phase_b.
  - LOCKING:
    - Good beat: good_cnt++ and last_phase updated.
    - When good_cnt reaches LOCK_CNT -> LOCKED.
    - Spacing fault -> UNLOCKED.
  - LOCKED:
    - Good beat: if phase_b < last_phase (unsigned), epoch++ (wraps modulo 2^EPOCH_WIDTH). Then last_phase=phase_b.
    - Spacing fault -> UNLOCKED. The beat is ignored and the FIFO is retained.
- Marker capture:
  - Only for a good beat in LOCKED with marker_v=1.
  - Pushes {epoch after this beat's update, phase_b}.
  - Markers in UNLOCKED or LOCKING, or on faulted beats, are discarded silently and not counted.
- Latency: a marker on beat cycle N gives ts_v=1 at N+1 if the FIFO was empty. Outputs come from flops.
- FIFO:
  - Pop when ts_v && ts_rdy.
  - A push while full with a pop in the same cycle is accepted.
  - A push while full with no pop is dropped: drop_cnt++, saturating at 255.
  - Head holds stable while ts_v && !ts_rdy.
- Async reset at any point returns to reset values immediately; FIFO contents are lost.

Optional Feature:
- Macro: TSU_INFO_RX_STEP_CHK_EN.
- Defined:
  - In LOCKING and LOCKED, each good beat also requires phase_b == last_phase + PHASE_STEP (modulo 2^PHASE_B_WIDTH).
  - Mismatch is a fault: step_err_cnt++ (saturating at 255), state -> UNLOCKED.
  - A wrap via the modulo addition is legal, and epoch increments as normal.
- Undefined: no step check; step_err_cnt tied to 0.

Decomposition:
- Add to tsu_pkg:
  - rx_state_e enum (UNLOCKED, LOCKING, LOCKED).
  - ts_entry packed struct {epoch, phase}, with a TSU_EPOCH_WIDTH=16 localparam for it.
  - Lock and step defaults.
- FIFO_DEPTH is a module parameter.
- One natural sub-module: tsu_ts_fifo, a parameterized synchronous FIFO of ts_entry with full/empty, push/pop and same-cycle full push+pop support.

Test Plan:
- Lock acquisition: beats every 8 clocks (FCLK_DIV_BITS=3), phase 0x100 steps -> lock rises on the clock after the 4th beat (1 entry + 3 good). No ts_v for markers sent before lock.
- Marker capture: locked, marker on phase 0x1234_5600 -> ts_v next clock, epoch 0, ts_phase 0x1234_5600. Hold ts_rdy=0 for 5 clocks -> head stable.
- Wrap: locked, beats 0xFFFF_FF00 then 0x0000_0000 with marker -> ts_epoch=1. Epoch 0xFFFF wrapping to 0 is checked likewise.
- Spacing fault: beat at 7 clocks, then a missing beat (16 clocks) -> lock falls the clock after each fault. Queued entries are still readable.
- Overflow: 6 markers with ts_rdy=0 -> 4 entries, drop_cnt=2. Full push plus pop in the same cycle -> accepted, drop_cnt unchanged.
- Step check (macro defined): phase jumps by 0x200 -> step_err_cnt=1, lock=0. Same stimulus without the macro -> lock stays 1, counter reads 0.
